// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared types and constants for the rhythm note scheduler.
//   state_e    : scheduler FSM states
//   lane_t     : arrow lane index (4 lanes)
//   KEY_*      : keycodes that drive song start / clear / abort
//   END_MARK   : chart spawn-time value that marks the end of a song
package rhythm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] lane_t;

  localparam logic [7:0]  KEY_START = 8'h2C;
  localparam logic [7:0]  KEY_CLEAR = 8'h01;
  localparam logic [7:0]  KEY_ABORT = 8'h29;
  localparam logic [11:0] END_MARK  = 12'hFFF;

endpackage

// File: rtl/rhythm_note_scheduler_slot_allocator.sv
// slot_allocator: combinational lowest-index free-slot picker.
//   busy_i     [N] : slot occupancy
//   grant_o    [N] : one-hot, lowest slot with busy == 0 (all zero if none)
//   any_free_o      : at least one slot is free
module slot_allocator #(
  parameter int N = 8
) (
  input  logic [N-1:0] busy_i,
  output logic [N-1:0] grant_o,
  output logic         any_free_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!busy_i[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_free_o = ~&busy_i;

endmodule

// File: rtl/rhythm_note_scheduler.sv
// rhythm_note_scheduler: song sequencer for the arrow dropper pool.
// Walks the chart ROM against a frame counter, launches each due note into
// the lowest free dropper slot, tracks slot occupancy and accumulates score.
//   frame_clk, Reset            : clock, synchronous active-high reset
//   keycode                     : start / clear / abort keys
//   chart_addr/time/lane        : combinational chart ROM interface
//   slot_done, slot_hit         : dropper completion pulses and hit flags
//   launch, launch_lane         : one-hot spawn pulse and its lane
//   flush                       : abort pulse returning droppers to idle
//   busy, frame_count           : slot occupancy, song time
//   score, dropped              : saturating hit / skipped-note counters
//   playing, song_over          : PLAY-or-DRAIN, DONE status
module rhythm_note_scheduler
  import rhythm_pkg::*;
#(
  parameter int         NUM_SLOTS = 8,
  parameter int         ADDR_W    = 6,
  parameter int         T_W       = 12,
  parameter logic [7:0] START_KEY = KEY_START,
  parameter logic [7:0] CLEAR_KEY = KEY_CLEAR,
  parameter logic [7:0] ABORT_KEY = KEY_ABORT
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  output logic [ADDR_W-1:0]    chart_addr,
  input  logic [T_W-1:0]       chart_time,
  input  lane_t                chart_lane,
  input  logic [NUM_SLOTS-1:0] slot_done,
  input  logic [NUM_SLOTS-1:0] slot_hit,
  output logic [NUM_SLOTS-1:0] launch,
  output lane_t                launch_lane,
  output logic                 flush,
  output logic [NUM_SLOTS-1:0] busy,
  output logic [T_W-1:0]       frame_count,
  output logic [7:0]           score,
  output logic [7:0]           dropped,
  output logic                 playing,
  output logic                 song_over
);

  localparam logic [T_W-1:0]    END_T     = {T_W{1'b1}};
  // Song time stops one short of the end marker so no real time aliases it.
  localparam logic [T_W-1:0]    FRAME_MAX = {{(T_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] IDX_MAX   = {ADDR_W{1'b1}};

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  state_e                state_q,   state_d;
  logic [T_W-1:0]        frame_q,   frame_d;
  logic [ADDR_W-1:0]     idx_q,     idx_d;
  logic [NUM_SLOTS-1:0]  busy_q,    busy_d;
  logic [NUM_SLOTS-1:0]  launch_q,  launch_d;
  lane_t                 lane_q,    lane_d;
  logic                  flush_q,   flush_d;
  logic [7:0]            score_q,   score_d;
  logic [7:0]            dropped_q, dropped_d;

  logic [NUM_SLOTS-1:0]  grant;
  logic                  any_free;
  logic [T_W-1:0]        frame_inc;
  logic                  at_end;
  logic                  abort_key;
  logic [7:0]            hits;

  slot_allocator #(.N(NUM_SLOTS)) u_alloc (
    .busy_i     (busy_q),
    .grant_o    (grant),
    .any_free_o (any_free)
  );

  assign frame_inc = (frame_q == FRAME_MAX) ? frame_q : frame_q + 1'b1;
  // The last ROM entry doubles as an end marker so note_idx never wraps.
  assign at_end    = (chart_time == END_T) || (idx_q == IDX_MAX);
  assign abort_key = (keycode == ABORT_KEY);
  // Only completions on occupied slots score.
  assign hits      = popcount(slot_done & slot_hit & busy_q);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    busy_d    = busy_q & ~slot_done;
    launch_d  = '0;
    lane_d    = '0;
    flush_d   = 1'b0;
    score_d   = score_q;
    dropped_d = dropped_q;

    case (state_q)
      IDLE: begin
        frame_d   = '0;
        idx_d     = '0;
        score_d   = '0;
        dropped_d = '0;
        if (keycode == START_KEY) state_d = PLAY;
      end

      PLAY, DRAIN: begin
        if (abort_key) begin
          state_d   = IDLE;
          flush_d   = 1'b1;
          busy_d    = '0;
          frame_d   = '0;
          idx_d     = '0;
          score_d   = '0;
          dropped_d = '0;
        end else begin
          score_d = sat_add8(score_q, hits);
          if (state_q == PLAY) begin
            frame_d = frame_inc;
            if (at_end) begin
              state_d = DRAIN;
            // Launch is registered, so a note is judged against the frame
            // being entered; the pulse then coincides with its spawn frame.
            end else if (chart_time <= frame_inc) begin
              idx_d = idx_q + 1'b1;
              if (any_free) begin
                launch_d = grant;
                lane_d   = chart_lane;
                busy_d   = busy_d | grant;
              end else begin
                dropped_d = sat_add8(dropped_q, 8'd1);
              end
            end
          end else if (busy_q == '0) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (keycode == CLEAR_KEY) begin
          state_d   = IDLE;
          frame_d   = '0;
          idx_d     = '0;
          score_d   = '0;
          dropped_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Register stage: all state and registered outputs
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      busy_q    <= '0;
      launch_q  <= '0;
      lane_q    <= '0;
      flush_q   <= 1'b0;
      score_q   <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      launch_q  <= launch_d;
      lane_q    <= lane_d;
      flush_q   <= flush_d;
      score_q   <= score_d;
      dropped_q <= dropped_d;
    end
  end

  assign chart_addr  = idx_q;
  assign launch      = launch_q;
  assign launch_lane = lane_q;
  assign flush       = flush_q;
  assign busy        = busy_q;
  assign frame_count = frame_q;
  assign score       = score_q;
  assign dropped     = dropped_q;
  assign playing     = (state_q == PLAY) || (state_q == DRAIN);
  assign song_over   = (state_q == DONE);

endmodule

// File: tb/tb_rhythm_note_scheduler.sv
module tb_rhythm_note_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic [5:0]  chart_addr;
  logic [11:0] chart_time;
  logic [1:0]  chart_lane;
  logic [7:0]  slot_done = 8'h00;
  logic [7:0]  slot_hit = 8'h00;
  logic [7:0]  launch;
  logic [1:0]  launch_lane;
  logic        flush;
  logic [7:0]  busy;
  logic [11:0] frame_count;
  logic [7:0]  score;
  logic [7:0]  dropped;
  logic        playing;
  logic        song_over;

  logic [11:0] ct [64];
  logic [1:0]  cl [64];

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  assign chart_time = ct[chart_addr];
  assign chart_lane = cl[chart_addr];

  rhythm_note_scheduler dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .chart_addr  (chart_addr),
    .chart_time  (chart_time),
    .chart_lane  (chart_lane),
    .slot_done   (slot_done),
    .slot_hit    (slot_hit),
    .launch      (launch),
    .launch_lane (launch_lane),
    .flush       (flush),
    .busy        (busy),
    .frame_count (frame_count),
    .score       (score),
    .dropped     (dropped),
    .playing     (playing),
    .song_over   (song_over)
  );

  typedef struct {
    logic [7:0]  key;
    logic [7:0]  done;
    logic [7:0]  hit;
    logic [7:0]  launch;
    logic [1:0]  lane;
    logic [7:0]  busy;
    logic [11:0] frame;
    logic [7:0]  score;
    logic        playing;
    logic        over;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_chart();
    for (int i = 0; i < 64; i++) begin
      ct[i] = 12'hFFF;
      cl[i] = 2'd0;
    end
  endtask

  initial begin
    clear_chart();

    // ---- reset state ----
    tick(); tick();
    Reset = 1'b0;
    chk("rst_launch", 32'(launch), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame", 32'(frame_count), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_dropped", 32'(dropped), 32'h0);
    chk("rst_playing", 32'(playing), 32'h0);
    chk("rst_over", 32'(song_over), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_addr", 32'(chart_addr), 32'h0);

    // ---- single note at t=3, drain, done, clear ----
    ct[0] = 12'd3; cl[0] = 2'd2;
    keycode = 8'h2C; tick(); keycode = 8'h00;
    chk("s1_playing", 32'(playing), 32'h1);
    chk("s1_frame0", 32'(frame_count), 32'h0);
    tick();
    chk("s1_frame1", 32'(frame_count), 32'h1);
    begin
      int n = 0;
      while (launch == 8'h00 && n < 10) begin tick(); n++; end
      chk("s1_launch_seen", 32'(n < 10), 32'h1);
    end
    chk("s1_launch", 32'(launch), 32'h01);
    chk("s1_lane", 32'(launch_lane), 32'h2);
    chk("s1_launch_frame", 32'(frame_count), 32'h3);
    tick();
    chk("s1_pulse_end", 32'(launch), 32'h0);
    chk("s1_drain_playing", 32'(playing), 32'h1);
    slot_done = 8'h01; slot_hit = 8'h01; tick(); slot_done = 8'h00; slot_hit = 8'h00;
    chk("s1_busy_clr", 32'(busy), 32'h0);
    chk("s1_score", 32'(score), 32'h1);
    tick();
    chk("s1_over", 32'(song_over), 32'h1);
    chk("s1_over_playing", 32'(playing), 32'h0);
    chk("s1_score_held", 32'(score), 32'h1);
    keycode = 8'h01; tick(); keycode = 8'h00;
    chk("s1_clear_over", 32'(song_over), 32'h0);
    chk("s1_clear_score", 32'(score), 32'h0);

    // ---- table: three notes at t=5, completions, reuse of slot 0 ----
    clear_chart();
    ct[0] = 12'd5; cl[0] = 2'd0;
    ct[1] = 12'd5; cl[1] = 2'd1;
    ct[2] = 12'd5; cl[2] = 2'd3;
    ct[3] = 12'd9; cl[3] = 2'd2;
    //          key    done   hit    launch lane busy   frame   score playing over
    tbl[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 12'd1,  8'd0, 1'b1, 1'b0};
    tbl[1]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 12'd2,  8'd0, 1'b1, 1'b0};
    tbl[2]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 12'd3,  8'd0, 1'b1, 1'b0};
    tbl[3]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 12'd4,  8'd0, 1'b1, 1'b0};
    tbl[4]  = '{8'h00, 8'h00, 8'h00, 8'h01, 2'd0, 8'h01, 12'd5,  8'd0, 1'b1, 1'b0};
    tbl[5]  = '{8'h00, 8'h00, 8'h00, 8'h02, 2'd1, 8'h03, 12'd6,  8'd0, 1'b1, 1'b0};
    tbl[6]  = '{8'h00, 8'h00, 8'h00, 8'h04, 2'd3, 8'h07, 12'd7,  8'd0, 1'b1, 1'b0};
    // slot 7 is idle: its done/hit must not score
    tbl[7]  = '{8'h00, 8'h85, 8'h81, 8'h00, 2'd0, 8'h02, 12'd8,  8'd1, 1'b1, 1'b0};
    tbl[8]  = '{8'h00, 8'h00, 8'h00, 8'h01, 2'd2, 8'h03, 12'd9,  8'd1, 1'b1, 1'b0};
    tbl[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h03, 12'd10, 8'd1, 1'b1, 1'b0};
    tbl[10] = '{8'h00, 8'h03, 8'h03, 8'h00, 2'd0, 8'h00, 12'd10, 8'd3, 1'b1, 1'b0};
    tbl[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 12'd10, 8'd3, 1'b0, 1'b1};
    tbl[12] = '{8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 12'd0,  8'd0, 1'b0, 1'b0};
    keycode = 8'h2C; tick(); keycode = 8'h00;
    for (int i = 0; i < 13; i++) begin
      keycode = tbl[i].key; slot_done = tbl[i].done; slot_hit = tbl[i].hit;
      tick();
      keycode = 8'h00; slot_done = 8'h00; slot_hit = 8'h00;
      chk($sformatf("t%0d_launch", i), 32'(launch), 32'(tbl[i].launch));
      chk($sformatf("t%0d_lane", i), 32'(launch_lane), 32'(tbl[i].lane));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("t%0d_frame", i), 32'(frame_count), 32'(tbl[i].frame));
      chk($sformatf("t%0d_score", i), 32'(score), 32'(tbl[i].score));
      chk($sformatf("t%0d_playing", i), 32'(playing), 32'(tbl[i].playing));
      chk($sformatf("t%0d_over", i), 32'(song_over), 32'(tbl[i].over));
    end

    // ---- nine notes at t=2: pool exhausted, ninth dropped, abort in DRAIN ----
    clear_chart();
    for (int i = 0; i < 9; i++) begin
      ct[i] = 12'd2; cl[i] = 2'(i % 4);
    end
    keycode = 8'h2C; tick(); keycode = 8'h00;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("s3_launch%0d", k), 32'(launch), 32'(8'h01 << k));
      chk($sformatf("s3_lane%0d", k), 32'(launch_lane), 32'(k % 4));
      chk($sformatf("s3_frame%0d", k), 32'(frame_count), 32'(k + 2));
    end
    tick();
    chk("s3_no_launch", 32'(launch), 32'h0);
    chk("s3_dropped", 32'(dropped), 32'h1);
    chk("s3_busy_full", 32'(busy), 32'hFF);
    chk("s3_addr", 32'(chart_addr), 32'd9);
    tick();
    keycode = 8'h29; tick(); keycode = 8'h00;
    chk("s3_flush", 32'(flush), 32'h1);
    chk("s3_abort_busy", 32'(busy), 32'h0);
    chk("s3_abort_dropped", 32'(dropped), 32'h0);
    chk("s3_abort_playing", 32'(playing), 32'h0);

    // ---- abort during PLAY with busy=0F, restart from note 0, reset mid-PLAY ----
    clear_chart();
    for (int i = 0; i < 4; i++) begin
      ct[i] = 12'd1; cl[i] = 2'(i);
    end
    ct[4] = 12'd50; cl[4] = 2'd1;
    keycode = 8'h2C; tick(); keycode = 8'h00;
    begin
      int n = 0;
      while (busy != 8'h0F && n < 20) begin tick(); n++; end
      chk("s5_busy_0f", 32'(busy), 32'h0F);
    end
    slot_done = 8'h01; slot_hit = 8'h01; tick(); slot_done = 8'h00; slot_hit = 8'h00;
    chk("s5_score", 32'(score), 32'h1);
    chk("s5_busy_0e", 32'(busy), 32'h0E);
    keycode = 8'h29; tick(); keycode = 8'h00;
    chk("s5_flush", 32'(flush), 32'h1);
    chk("s5_busy", 32'(busy), 32'h0);
    chk("s5_score_clr", 32'(score), 32'h0);
    chk("s5_playing", 32'(playing), 32'h0);
    chk("s5_launch", 32'(launch), 32'h0);
    chk("s5_addr", 32'(chart_addr), 32'h0);
    tick();
    chk("s5_flush_end", 32'(flush), 32'h0);
    keycode = 8'h2C; tick(); keycode = 8'h00;
    chk("s5_restart", 32'(playing), 32'h1);
    chk("s5_restart_addr", 32'(chart_addr), 32'h0);
    tick();
    chk("s5_relaunch", 32'(launch), 32'h01);
    chk("s5_relaunch_addr", 32'(chart_addr), 32'h1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("s6_rst_launch", 32'(launch), 32'h0);
    chk("s6_rst_busy", 32'(busy), 32'h0);
    chk("s6_rst_frame", 32'(frame_count), 32'h0);
    chk("s6_rst_playing", 32'(playing), 32'h0);
    chk("s6_rst_addr", 32'(chart_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rhythm_note_scheduler.md
Name: rhythm_note_scheduler

Overview:
- Song-level sequencer for the arrow dropper pool.
- Walks a chart table of (spawn frame, lane) entries against a frame counter and assigns each note to a free dropper slot with a one-cycle launch pulse.
- Tracks slot occupancy and accumulates hit score from dropper completions.
- Sits between the keyboard keycode path, the chart ROM and the dropper instances; its score feeds the HUD.

Parameters:
- NUM_SLOTS, 8, number of dropper slots managed.
- ADDR_W, 6, chart ROM address width (64 entries).
- T_W, 12, frame counter / chart time width.
- START_KEY, 8'h2C, keycode that starts a song (space).
- CLEAR_KEY, 8'h01, keycode that returns DONE to IDLE.
- ABORT_KEY, 8'h29, keycode that aborts a song (Esc).

Ports:
- frame_clk  in  1  frame clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high.
- keycode  in  8  current key.
- chart_addr  out  ADDR_W  chart ROM index (note_idx).
- chart_time  in  T_W  spawn frame of the addressed entry; combinational ROM, valid the same cycle; 12'hFFF = end marker.
- chart_lane  in  2  lane of the addressed entry.
- slot_done  in  NUM_SLOTS  per-slot one-cycle pulse: dropper finished.
- slot_hit  in  NUM_SLOTS  qualifies slot_done: 1 = hit, 0 = miss.
- launch  out  NUM_SLOTS  one-hot, one-cycle spawn pulse.
- launch_lane  out  2  lane for the pulsed slot; valid while launch != 0.
- flush  out  1  one-cycle pulse; droppers return to idle.
- busy  out  NUM_SLOTS  slot occupancy.
- frame_count  out  T_W  song time.
- score  out  8  hit count, saturating at 255.
- dropped  out  8  notes skipped for lack of a free slot, saturating at 255.
- playing  out  1  high in PLAY or DRAIN.
- song_over  out  1  high in DONE.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, note_idx 0.
- States IDLE, PLAY, DRAIN, DONE.
- IDLE:
  - frame_count, note_idx, score and dropped are held at 0.
  - keycode == START_KEY -> PLAY on the next edge.
- PLAY:
  - frame_count increments by 1 per cycle and saturates at 2^T_W-2, so it never reaches the end marker.
  - Launch condition: chart_time != 12'hFFF and chart_time <= frame_count.
  - At most one note is processed per cycle. Notes sharing a frame spawn on consecutive cycles.
  - If any slot is free, pick the lowest-index slot with busy == 0, using busy as registered at the start of the cycle.
    - Assert launch[i] for exactly one cycle with launch_lane = chart_lane.
    - Set busy[i] at that edge; note_idx++.
  - If no slot is free: no launch, dropped++ (saturating), note_idx++.
  - chart_time == 12'hFFF -> DRAIN; note_idx is held.
  - note_idx at its maximum with no marker present: treated as an end marker.
- DRAIN:
  - No launches.
  - busy == 0 -> DONE.
- DONE:
  - score and dropped are held.
  - keycode == CLEAR_KEY -> IDLE.
- Slot completion, in every state:
  - slot_done[i] clears busy[i] at the edge.
  - score increases by popcount(slot_done & slot_hit & busy), saturating.
  - slot_done on a non-busy slot is ignored.
- Launch and done on the same slot in the same cycle cannot occur: allocation uses the pre-edge busy, so a slot freed this cycle is reusable next cycle.
- Abort: keycode == ABORT_KEY in PLAY or DRAIN:
  - -> IDLE.
  - One-cycle flush; busy cleared; no launch that cycle.
  - score and dropped cleared on IDLE entry.
- Priority within a cycle: Reset > abort > end marker > launch.
- Outputs launch, flush and busy are registered; frame_count is registered.

Decomposition:
- Package rhythm_pkg:
  - State enum (IDLE, PLAY, DRAIN, DONE).
  - Keycode constants.
  - END_MARK = 12'hFFF.
  - Lane typedef (logic [1:0]).
- Sub-module slot_allocator:
  - Combinational lowest-index free-slot priority encoder.
  - Inputs: busy. Outputs: grant one-hot, any_free.
- Scheduler FSM, counters and score popcount stay in rhythm_note_scheduler.

Test Plan:
1. Reset, then keycode=8'h2C -> playing=1 next cycle; frame_count 0,1,2…; chart {t=3,lane 2; FFF} -> launch=8'b0000_0001, launch_lane=2 in the cycle frame_count==3; DRAIN follows.
2. Chart {5,0; 5,1; 5,3; FFF} -> launches on slots 0,1,2 at frame_count 5,6,7 with lanes 0,1,3; busy=8'b0000_0111.
3. NUM_SLOTS=8, nine notes at t=2, no slot_done -> slots 0–7 launched on cycles 2–9; ninth note gives dropped=1 and no launch.
4. slot_done=8'b0000_0101, slot_hit=8'b0000_0001 with both slots busy -> score +1, busy bits 0 and 2 cleared; next note lands in slot 0.
5. ABORT_KEY during PLAY with busy=8'h0F -> flush pulse for one cycle, busy=0, state IDLE, score=0; a later START_KEY restarts from note_idx 0.
6. All notes complete in DRAIN -> song_over=1 with score held; keycode=8'h01 -> IDLE; Reset mid-PLAY -> all outputs 0 the next cycle.
